poly_deflate_32: RTL and testbench

Sequential synthetic-division (Horner deflation) engine for degree-6 polynomials over 32-bit modular integers. It is the inverse companion of the pipelined FMA evaluator: instead of reducing a coefficient set and a point to a single value, it takes a coefficient stream and a root `r`. It returns the quotient coefficients of p(x)/(x − r) followed by the remainder p(r). A single shared multiply-add datapath sits between a coefficient source and a consumer, with valid/ready handshakes on both sides.

---
 rtl/poly_deflate_32.sv | 194 +++++++++++++++++++
 tb/tb_poly_deflate_32.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_deflate_32.sv
// poly_deflate_32
//   Sequential synthetic-division (Horner deflation) engine. A job consumes
//   DEG+1 coefficients (highest order first) and a root r, and emits the
//   quotient coefficients of p(x)/(x - r) followed by the remainder p(r).
//   A single multiply-add evaluates b_k = c_k + r*b_{k+1} (mod 2^32) per beat.
//
// Optional feature macro: DEFLATE_CARRY_EN
//   When defined, the multiply is built full width (64-bit product, 33-bit
//   sum) so that overflow can be detected on the sticky ovf flag. Data
//   results stay truncated either way. When undefined, ovf is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   coefficient beat valid
//   in_ready   engine can accept a coefficient (LOAD state)
//   in_coef    coefficient, c_DEG first down to c_0
//   in_root    root r, sampled only on the first beat of a job
//   out_valid  result beat valid (SEND state)
//   out_ready  consumer accepts the result beat
//   out_data   b_DEG .. b_1 (quotient), then b_0 (remainder)
//   out_last   marks the remainder beat
//   ovf        sticky overflow flag for the current job
module poly_deflate_32 #(
  parameter int DEG = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_coef,
  input  logic [31:0] in_root,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        ovf
);

  localparam int IDX_W = $clog2(DEG + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEG);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      root_q, root_d;
  logic [31:0]      coef_q, coef_d;
  logic [31:0]      res_q, res_d;

  logic             load_fire;
  logic             send_fire;
  logic             first_beat;
  logic [31:0]      acc_eff;
  logic [31:0]      mac_result;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (in_valid) state_d = ST_MAC;
      ST_MAC:  state_d = ST_SEND;
      ST_SEND: if (out_ready) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = (state_q == ST_SEND);
    out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    out_data  = res_q;
  end

  assign load_fire  = in_ready && in_valid;
  assign send_fire  = out_valid && out_ready;
  assign first_beat = (idx_q == '0);

  // The first beat of a job starts from b = 0, which drops any acc left
  // over from the previous job without needing an explicit clear cycle.
  assign acc_eff = first_beat ? 32'd0 : acc_q;

  // ---------------------------------------------------------------------
  // Multiply-add datapath
  // ---------------------------------------------------------------------
`ifdef DEFLATE_CARRY_EN
  logic [63:0] prod_full;
  logic [32:0] sum_full;
  logic        mac_ovf;
  logic        ovf_q, ovf_d;

  assign prod_full  = {32'd0, root_q} * {32'd0, acc_eff};
  assign sum_full   = {1'b0, coef_q} + {1'b0, prod_full[31:0]};
  assign mac_result = sum_full[31:0];
  assign mac_ovf    = (|prod_full[63:32]) | sum_full[32];

  // Sticky within a job; cleared when beat 0 of the next job is accepted.
  always_comb begin
    ovf_d = ovf_q;
    if (load_fire && first_beat) begin
      ovf_d = 1'b0;
    end else if (state_q == ST_MAC && mac_ovf) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic [31:0] prod_lo;

  assign prod_lo    = root_q * acc_eff;
  assign mac_result = coef_q + prod_lo;
  assign ovf        = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    idx_d  = idx_q;
    acc_d  = acc_q;
    root_d = root_q;
    coef_d = coef_q;
    res_d  = res_q;

    if (load_fire) begin
      coef_d = in_coef;
      if (first_beat) begin
        root_d = in_root;
      end
    end

    if (state_q == ST_MAC) begin
      res_d = mac_result;
      acc_d = mac_result;
    end

    // idx only wraps on the remainder handshake.
    if (send_fire) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      acc_q  <= 32'd0;
      root_q <= 32'd0;
      coef_q <= 32'd0;
      res_q  <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      root_q <= root_d;
      coef_q <= coef_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: tb/tb_poly_deflate_32.sv
module tb_poly_deflate_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_coef;
  logic [31:0] in_root;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        ovf;

  poly_deflate_32 #(.DEG(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .in_root   (in_root),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_mode = 1'b0;

`ifdef DEFLATE_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  // Directed vectors (index 0 = c6 / b6)
  logic [31:0] coefs_a [7] = '{32'd2, 32'd3, 32'd2, 32'd7, 32'd8, 32'd2, 32'd4};
  logic [31:0] exp_r1  [7] = '{32'd2, 32'd5, 32'd7, 32'd14, 32'd22, 32'd24, 32'd28};
  logic [31:0] exp_r2  [7] = '{32'd2, 32'd7, 32'd16, 32'd39, 32'd86, 32'd174, 32'd352};
  logic [31:0] coefs_o [7] = '{32'h10000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] exp_o   [7] = '{32'h10000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Consumer back-pressure: tied high or random, changed just after posedge.
  always @(posedge clk) begin
    #1 out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: sampled on negedge, away from the active edge.
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data = 32'd0;
  logic        stall_last = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_data_stable", out_data, stall_data);
        check("stall_last_stable", {31'd0, out_last}, {31'd0, stall_last});
      end
      if (out_valid) begin
        check("in_ready_low_in_send", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", {31'd0, out_last}, {31'd0, e.last});
          check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          $display("beat data=0x%08h last=%0b ovf=%0b", out_data, out_last, ovf);
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Present one coefficient and wait (bounded) for acceptance.
  task automatic send_beat(input logic [31:0] c, input logic [31:0] r,
                           input bit chk_lat, output bit ok);
    int budget;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_coef  = c;
    in_root  = r;
    budget   = 100;
    while (!ok && budget > 0) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        budget--;
      end
    end
    #1;
    in_valid = 1'b0;
    in_coef  = 32'hDEAD_BEEF;
    in_root  = 32'hDEAD_BEEF;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready, expected acceptance");
    end else if (chk_lat) begin
      @(negedge clk);
      check("latency_mac_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("latency_send_valid", {31'd0, out_valid}, 32'd1);
    end
  endtask

  task automatic run_job(input logic [31:0] c [7], input logic [31:0] r,
                         input logic [31:0] e [7], input logic [6:0] ovf_exp,
                         input int nbeats, input bit chk_lat);
    bit ok;
    for (int i = 0; i < nbeats; i++) begin
      exp_q.push_back({e[i], (i == 6), ovf_exp[i]});
      send_beat(c[i], (i == 0) ? r : 32'hDEAD_BEEF, chk_lat, ok);
    end
  endtask

  task automatic drain();
    int budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    logic [6:0] ovf_ovr;
    bit ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_coef   = 32'd0;
    in_root   = 32'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // r=1 and r=2 with out_ready tied high, latency checked per beat
    run_job(coefs_a, 32'd1, exp_r1, 7'd0, 7, 1'b1);
    drain();
    run_job(coefs_a, 32'd2, exp_r2, 7'd0, 7, 1'b1);
    drain();

    // r=2 under random back-pressure
    rnd_mode = 1'b1;
    run_job(coefs_a, 32'd2, exp_r2, 7'd0, 7, 1'b0);
    drain();
    rnd_mode = 1'b0;

    // Overflow job: b5 = 0x10000*0x10000 wraps to 0; flag sticks through b0
    ovf_ovr = CARRY ? 7'b111_1110 : 7'b000_0000;
    run_job(coefs_o, 32'h10000, exp_o, ovf_ovr, 7, 1'b0);
    // Back-to-back r=1 then r=2: ovf cleared, fresh root, no acc carry-over
    run_job(coefs_a, 32'd1, exp_r1, 7'd0, 7, 1'b0);
    run_job(coefs_a, 32'd2, exp_r2, 7'd0, 7, 1'b0);
    drain();

    // Abort mid-job: two beats come out, the third is discarded by reset
    run_job(coefs_a, 32'd1, exp_r1, 7'd0, 2, 1'b0);
    drain();
    send_beat(coefs_a[2], 32'hDEAD_BEEF, 1'b0, ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midjob_reset");
    rst_n = 1'b1;
    run_job(coefs_a, 32'd1, exp_r1, 7'd0, 7, 1'b0);
    drain();

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
